wfg_drive_pat_cfg_seq: RTL

Wishbone master that programs the drive_pat register slave. On a start pulse it snapshots a full register image and writes it in a fixed order, disabling the pattern driver first and enabling it last. The write order guarantees the driver never runs on a half-updated configuration. It sits between the system configuration logic and the drive_pat Wishbone slave port; optional readback verification and an ack timeout flag bus faults.

---
 rtl/wfg_drive_pat_cfg_seq.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wfg_drive_pat_cfg_seq.sv
// Wishbone master that loads a drive_pat register image: CTRL off, CFG, PATSEL0, PATSEL1, CTRL on.
// Define WFG_DRIVE_PAT_CFG_SEQ_VERIFY_EN to add readback verification of the image after the writes.
module wfg_drive_pat_cfg_seq #(
  parameter int unsigned BUSW    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [31:0]       ctrl_en_i,
  input  logic [31:0]       cfg_i,
  input  logic [31:0]       patsel0_i,
  input  logic [31:0]       patsel1_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  input  logic [BUSW-1:0]   wbm_dat_i,
  input  logic              wbm_ack_i
);
  localparam int unsigned SELW    = BUSW / 8;
  localparam int unsigned STEPW   = 3;
  localparam int unsigned TMOW    = 8;
  localparam int unsigned LAST_WR = 4;
`ifdef WFG_DRIVE_PAT_CFG_SEQ_VERIFY_EN
  localparam int unsigned LAST_RD = 3;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2
`ifdef WFG_DRIVE_PAT_CFG_SEQ_VERIFY_EN
    , S_READ = 2'd3
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [STEPW-1:0]  step_q, step_d;
  logic [TMOW-1:0]   tmo_q, tmo_d;
  logic [BUSW-1:0]   ctrl_q, ctrl_d, cfg_q, cfg_d, pat0_q, pat0_d, pat1_q, pat1_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [BUSW-1:0]   adr_q, adr_d, dat_q, dat_d;
  logic [BUSW-1:0]   wr_adr_c, wr_dat_c;
  logic              acked_c;

  // Write image in order: CTRL cleared first, CTRL enable value last
  always_comb begin
    wr_adr_c = '0;
    wr_dat_c = '0;
    case (step_q)
      3'd0:    begin wr_adr_c = BUSW'(4'h0); wr_dat_c = '0;     end
      3'd1:    begin wr_adr_c = BUSW'(4'h4); wr_dat_c = cfg_q;  end
      3'd2:    begin wr_adr_c = BUSW'(4'h8); wr_dat_c = pat0_q; end
      3'd3:    begin wr_adr_c = BUSW'(4'hC); wr_dat_c = pat1_q; end
      default: begin wr_adr_c = BUSW'(4'h0); wr_dat_c = ctrl_q; end
    endcase
  end

`ifdef WFG_DRIVE_PAT_CFG_SEQ_VERIFY_EN
  logic [BUSW-1:0] rd_adr_c, rd_exp_c;

  always_comb begin
    rd_adr_c = '0;
    rd_exp_c = '0;
    case (step_q)
      3'd0:    begin rd_adr_c = BUSW'(4'h4); rd_exp_c = cfg_q;  end
      3'd1:    begin rd_adr_c = BUSW'(4'h8); rd_exp_c = pat0_q; end
      3'd2:    begin rd_adr_c = BUSW'(4'hC); rd_exp_c = pat1_q; end
      default: begin rd_adr_c = BUSW'(4'h0); rd_exp_c = ctrl_q; end
    endcase
  end
`else
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i;
`endif

  assign acked_c = stb_q & wbm_ack_i;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    ctrl_d  = ctrl_q;
    cfg_d   = cfg_q;
    pat0_d  = pat0_q;
    pat1_d  = pat1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ctrl_d  = BUSW'(ctrl_en_i);
          cfg_d   = BUSW'(cfg_i & 32'h0001_FFFF);
          pat0_d  = BUSW'(patsel0_i);
          pat1_d  = BUSW'(patsel1_i);
          error_d = 1'b0;
          busy_d  = 1'b1;
          step_d  = '0;
          tmo_d   = '0;
          state_d = S_WRITE;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = BUSW'(4'h0);
          dat_d   = '0;
        end
      end

      S_WRITE: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = wr_adr_c;
          dat_d = wr_dat_c;
          tmo_d = '0;
        end else if (acked_c) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (step_q == STEPW'(LAST_WR)) begin
            step_d  = '0;
`ifdef WFG_DRIVE_PAT_CFG_SEQ_VERIFY_EN
            state_d = S_READ;
`else
            state_d = S_FINISH;
`endif
          end else begin
            step_d = step_q + STEPW'(1);
          end
        end else if (tmo_q == TMOW'(TIMEOUT)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TMOW'(1);
        end
      end

`ifdef WFG_DRIVE_PAT_CFG_SEQ_VERIFY_EN
      // A mismatch is recorded but the remaining reads still run
      S_READ: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = 1'b0;
          adr_d = rd_adr_c;
          dat_d = '0;
          tmo_d = '0;
        end else if (acked_c) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
          if (wbm_dat_i != rd_exp_c) error_d = 1'b1;
          if (step_q == STEPW'(LAST_RD)) state_d = S_FINISH;
          else                           step_d  = step_q + STEPW'(1);
        end else if (tmo_q == TMOW'(TIMEOUT)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          error_d = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TMOW'(1);
        end
      end
`endif

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        we_d    = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    sel_d = cyc_d ? '1 : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      tmo_q   <= '0;
      ctrl_q  <= '0;
      cfg_q   <= '0;
      pat0_q  <= '0;
      pat1_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      ctrl_q  <= ctrl_d;
      cfg_q   <= cfg_d;
      pat0_q  <= pat0_d;
      pat1_q  <= pat1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule
